hilo_mdu_iter: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair for the EX stage.

---
 rtl/hilo_mdu_iter.sv | 161 ++++++++++++++++
 tb/tb_hilo_mdu_iter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu_iter.sv
// Multi-cycle multiply/divide unit owning HI/LO: MULT/DIV with MADD/MSUB accumulate,
// valid/ready issue, done pulse and flush-abort.
module hilo_mdu_iter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid_i,
  output logic            op_ready_o,
  input  logic [3:0]      op_code_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            div_zero_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam int unsigned CntMax = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [2:0]          op_q;
  logic [XLEN-1:0]     a_q, b_q, quo_q, rem_q, hi_q, lo_q;
  logic                done_q, div_zero_q;

  logic                accept;
  logic [2:0]          mul_op;
  logic [XLEN-1:0]     mul_a, mul_b;
  logic [2*XLEN-1:0]   ax, bx, prod, mul_res;
  logic                in_neg, a_neg, b_neg, div_by_zero;
  logic [XLEN-1:0]     dvs, rem_nx, quo_nx, rem_fix, quo_fix;
  logic [XLEN:0]       rem_sh, trial;

  assign accept = op_valid_i && (state_q == StIdle) && !flush_i;

  // With MUL_LAT == 1 the product is committed at the accept edge straight from the inputs.
  always_comb begin
    mul_op  = (state_q == StIdle) ? op_code_i[2:0] : op_q;
    mul_a   = (state_q == StIdle) ? src1_i : a_q;
    mul_b   = (state_q == StIdle) ? src2_i : b_q;
    ax      = {{XLEN{~mul_op[0] & mul_a[XLEN-1]}}, mul_a};
    bx      = {{XLEN{~mul_op[0] & mul_b[XLEN-1]}}, mul_b};
    prod    = ax * bx;
    mul_res = prod;
    case (mul_op[2:1])
      2'b10:   mul_res = {hi_q, lo_q} + prod;
      2'b11:   mul_res = {hi_q, lo_q} - prod;
      default: mul_res = prod;
    endcase
  end

  // Restoring step on magnitudes; the final step feeds the sign fix directly.
  always_comb begin
    in_neg      = ~op_code_i[0] & src1_i[XLEN-1];
    a_neg       = ~op_q[0] & a_q[XLEN-1];
    b_neg       = ~op_q[0] & b_q[XLEN-1];
    dvs         = b_neg ? -b_q : b_q;
    div_by_zero = (b_q == '0);
    rem_sh      = {rem_q, quo_q[XLEN-1]};
    trial       = rem_sh - {1'b0, dvs};
    rem_nx      = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
    quo_nx      = {quo_q[XLEN-2:0], ~trial[XLEN]};
    quo_fix     = (a_neg ^ b_neg) ? -quo_nx : quo_nx;
    rem_fix     = a_neg ? -rem_nx : rem_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            op_q <= op_code_i[2:0];
            a_q  <= src1_i;
            b_q  <= src2_i;
            case (op_code_i)
              4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7: begin
                if (MUL_LAT == 1) begin
                  {hi_q, lo_q} <= mul_res;
                  done_q       <= 1'b1;
                end else begin
                  state_q <= StMul;
                  cnt_q   <= CntW'(MUL_LAT - 2);
                end
              end
              4'd2, 4'd3: begin
                state_q <= StDiv;
                cnt_q   <= CntW'(XLEN - 1);
                quo_q   <= in_neg ? -src1_i : src1_i;
                rem_q   <= '0;
              end
              4'd8:    hi_q <= src1_i;
              4'd9:    lo_q <= src1_i;
              default: ;
            endcase
          end
        end
        StMul: begin
          if (flush_i) begin
            state_q <= StIdle;
          end else if (cnt_q == '0) begin
            {hi_q, lo_q} <= mul_res;
            done_q       <= 1'b1;
            state_q      <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StDiv: begin
          if (flush_i) begin
            state_q <= StIdle;
          end else if (cnt_q == '0) begin
            if (div_by_zero) begin
              hi_q       <= a_q;
              lo_q       <= '1;
              div_zero_q <= 1'b1;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign op_ready_o = (state_q == StIdle);
  assign busy_o     = (state_q != StIdle);
  assign done_o     = done_q;
  assign div_zero_o = div_zero_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_hilo_mdu_iter.sv
// Scoreboard bench for hilo_mdu_iter: directed ops push expected {div_zero, hi, lo};
// a negedge monitor pops and compares on every done pulse.
module tb_hilo_mdu_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid_i;
  logic        op_ready_o;
  logic [3:0]  op_code_i;
  logic [31:0] src1_i, src2_i;
  logic        flush_i;
  logic        busy_o, done_o, div_zero_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;
  logic [64:0] sb_q[$];
  logic [64:0] mon_exp;

  hilo_mdu_iter #(.XLEN(32), .MUL_LAT(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid_i (op_valid_i),
    .op_ready_o (op_ready_o),
    .op_code_i  (op_code_i),
    .src1_i     (src1_i),
    .src2_i     (src2_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .div_zero_o (div_zero_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_res(input logic [31:0] hi, input logic [31:0] lo, input logic dz);
    sb_q.push_back({dz, hi, lo});
  endtask

  // Presents one op for a single cycle; returns just after the accept edge (cycle 1).
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_valid_i = 1'b1;
    op_code_i  = op;
    src1_i     = a;
    src2_i     = b;
    @(posedge clk);
    #1 op_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int lat, input string name);
    int n = 0;
    for (int c = 1; c <= 100 && n == 0; c++) begin
      @(negedge clk);
      if (done_o) n = c;
    end
    chk(name, 65'(n), 65'(lat));
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (done_o) n++;
    end
  endtask

  task automatic flush_at(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int fcyc, input string name);
    logic [31:0] hi0, lo0;
    int n;
    hi0 = hi_o;
    lo0 = lo_o;
    issue(op, a, b);
    repeat (fcyc) @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    chk({name, "_ready"}, 65'(op_ready_o), 65'(1));
    chk({name, "_hilo"}, {1'b0, hi_o, lo_o}, {1'b0, hi0, lo0});
    count_done(40, n);
    chk({name, "_no_done"}, 65'(n), 65'(0));
  endtask

  always @(negedge clk) begin
    if (done_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got hi=%h lo=%h required no done", hi_o, lo_o);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("result", {div_zero_o, hi_o, lo_o}, mon_exp);
      end
    end else if (div_zero_o) begin
      checks++;
      errors++;
      $display("FAIL div_zero_without_done: got 1 required 0");
    end
  end

  initial begin
    int n;
    reset      = 1'b1;
    op_valid_i = 1'b0;
    op_code_i  = '0;
    src1_i     = '0;
    src2_i     = '0;
    flush_i    = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_hilo", {1'b0, hi_o, lo_o}, 65'(0));
    chk("rst_flags", {62'd0, op_ready_o, busy_o, done_o}, 65'b100);
    chk("rst_dz", 65'(div_zero_o), 65'(0));

    // MULT -2 * 3
    expect_res(32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    issue(4'd0, 32'hFFFFFFFE, 32'd3);
    wait_done(3, "mult_lat");

    // DIV -7 / 2, DIVU 7 / 0
    expect_res(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    issue(4'd2, 32'hFFFFFFF9, 32'd2);
    wait_done(33, "div_lat");
    expect_res(32'd7, 32'hFFFFFFFF, 1'b1);
    issue(4'd3, 32'd7, 32'd0);
    wait_done(33, "divu_zero_lat");

    // MTHI / MTLO then accumulate
    issue(4'd8, 32'd5, 32'd0);
    @(negedge clk);
    chk("mthi", {1'b0, hi_o, lo_o}, {1'b0, 32'd5, 32'hFFFFFFFF});
    chk("mthi_no_done", 65'(done_o), 65'(0));
    issue(4'd9, 32'd1, 32'd0);
    @(negedge clk);
    chk("mtlo", {1'b0, hi_o, lo_o}, {1'b0, 32'd5, 32'd1});
    expect_res(32'd6, 32'hFFFFFFFF, 1'b0);
    issue(4'd5, 32'hFFFFFFFF, 32'd2);
    wait_done(3, "maddu_lat");
    expect_res(32'd6, 32'hFFFFFFFE, 1'b0);
    issue(4'd6, 32'd1, 32'd1);
    wait_done(3, "msub_lat");

    // Flush blocks accept, flush mid-op, flush on the write edge
    @(negedge clk);
    op_valid_i = 1'b1;
    op_code_i  = 4'd8;
    src1_i     = 32'h1234;
    flush_i    = 1'b1;
    @(posedge clk);
    #1 op_valid_i = 1'b0;
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush_blocks_mthi", {1'b0, hi_o, lo_o}, {1'b0, 32'd6, 32'hFFFFFFFE});
    flush_at(4'd2, 32'd100, 32'd7, 10, "flush_div_c10");
    flush_at(4'd0, 32'd9, 32'd9, 2, "flush_mult_wr");
    flush_at(4'd2, 32'd100, 32'd7, 32, "flush_div_wr");

    // Reset mid-MULTU
    issue(4'd1, 32'd3, 32'd5);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_hilo", {1'b0, hi_o, lo_o}, 65'(0));
    chk("midrst_flags", {63'd0, op_ready_o, done_o}, 65'b10);
    count_done(10, n);
    chk("midrst_no_done", 65'(n), 65'(0));

    // op_valid held while busy: one accept only
    expect_res(32'd0, 32'd12, 1'b0);
    @(negedge clk);
    op_valid_i = 1'b1;
    op_code_i  = 4'd1;
    src1_i     = 32'd3;
    src2_i     = 32'd4;
    repeat (3) @(posedge clk);
    #1 op_valid_i = 1'b0;
    count_done(20, n);
    chk("held_valid_one_done", 65'(n), 65'(1));

    // Back-to-back: MULT accepted in the DIV done cycle
    expect_res(32'd2, 32'hFFFFFFF2, 1'b0);
    expect_res(32'hFFFFFFFF, 32'h00000000, 1'b0);
    issue(4'd2, 32'd100, 32'hFFFFFFF9);
    repeat (33) @(negedge clk);
    chk("b2b_div_done", 65'(done_o), 65'(1));
    op_valid_i = 1'b1;
    op_code_i  = 4'd0;
    src1_i     = 32'h80000000;
    src2_i     = 32'd2;
    @(posedge clk);
    #1 op_valid_i = 1'b0;
    wait_done(3, "b2b_mult_lat");

    // Signed MIN / -1 and signed divide by zero
    expect_res(32'd0, 32'h80000000, 1'b0);
    issue(4'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done(33, "div_min_lat");
    expect_res(32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
    issue(4'd2, 32'hFFFFFFFB, 32'd0);
    wait_done(33, "div_zero_signed_lat");

    repeat (5) @(negedge clk);
    chk("sb_empty", 65'(sb_q.size()), 65'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
